// File: rtl/piso_serializer_if.sv
// Word-input and serial-output bundle of the PISO serializer.
// Handshake: a word moves on a rising clk edge where in_valid & in_ready; in_ready never depends on in_valid.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with a one-word hold buffer for gapless frames.
// All serial outputs are registered; dbg_state_o is high while a frame is shifting.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    piso_serializer_if.slave  bus,
    output logic              dbg_state_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_last_q, ser_last_d;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] shifted;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) return w[WIDTH-1];
        else                return w[0];
    endfunction

    // Rotating rather than shifting keeps the next bit at the head; stale bits are never sent.
    if (MSB_FIRST != 0) begin : g_msb
        assign shifted = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
    end else begin : g_lsb
        assign shifted = {shift_q[0], shift_q[WIDTH-1:1]};
    end

    assign accept = bus.in_valid & ~hold_valid_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        cnt_d        = cnt_q;
        ser_out_d    = ser_out_q;
        ser_valid_d  = ser_valid_q;
        ser_first_d  = ser_first_q;
        ser_last_d   = ser_last_q;
        load         = 1'b0;
        load_word    = bus.in_data;

        unique case (state_q)
            IDLE: begin
                if (accept) load = 1'b1;
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    if (hold_valid_q) begin
                        load         = 1'b1;
                        load_word    = hold_q;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        ser_out_d   = 1'b0;
                        ser_valid_d = 1'b0;
                        ser_first_d = 1'b0;
                        ser_last_d  = 1'b0;
                    end
                end else begin
                    shift_d     = shifted;
                    cnt_d       = cnt_q + 1'b1;
                    ser_out_d   = head_bit(shifted);
                    ser_first_d = 1'b0;
                    ser_last_d  = (cnt_q == LAST - 1'b1);
                    if (accept) begin
                        hold_d       = bus.in_data;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new frame starts from either the input port or the hold buffer.
        if (load) begin
            state_d     = SHIFT;
            shift_d     = load_word;
            cnt_d       = '0;
            ser_out_d   = head_bit(load_word);
            ser_valid_d = 1'b1;
            ser_first_d = 1'b1;
            ser_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            cnt_q        <= '0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_first_q  <= 1'b0;
            ser_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            cnt_q        <= cnt_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            ser_first_q  <= ser_first_d;
            ser_last_q   <= ser_last_d;
        end
    end

    assign bus.in_ready  = ~hold_valid_q;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_first = ser_first_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.busy      = (state_q == SHIFT) | hold_valid_q;
    assign dbg_state_o   = (state_q == SHIFT);
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share one stimulus stream
// and are compared every cycle against a word-queue model of the transmitted bit stream.
module tb_piso_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         tb_valid = 1'b0;
    logic [W-1:0] tb_data = '0;
    logic         dbg_m, dbg_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: words still to be sent, oldest first; pos is the bit index on the wire now.
    logic [W-1:0] exp_q[$];
    int           pos = 0;
    logic [W-1:0] rx_m, rx_l;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) if_m ();
    piso_serializer_if #(.WIDTH(W)) if_l ();

    assign if_m.in_valid = tb_valid;
    assign if_m.in_data  = tb_data;
    assign if_l.in_valid = tb_valid;
    assign if_l.in_data  = tb_data;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(rst_n), .bus(if_m), .dbg_state_o(dbg_m)
    );
    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(rst_n), .bus(if_l), .dbg_state_o(dbg_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {dbg, busy, in_ready, ser_valid, ser_first, ser_last, ser_out}
    function automatic logic [6:0] exp_vec(input bit msb);
        logic [W-1:0] w;
        logic         b;
        if (exp_q.size() == 0) return 7'b0010000;
        w = exp_q[0];
        b = msb ? w[W-1-pos] : w[pos];
        return {1'b1, 1'b1, (exp_q.size() < 2), 1'b1, (pos == 0), (pos == W-1), b};
    endfunction

    task automatic check_outputs(input string sfx);
        check_eq({"m_", sfx}, 32'({dbg_m, if_m.busy, if_m.in_ready, if_m.ser_valid,
                                  if_m.ser_first, if_m.ser_last, if_m.ser_out}), 32'(exp_vec(1'b1)));
        check_eq({"l_", sfx}, 32'({dbg_l, if_l.busy, if_l.in_ready, if_l.ser_valid,
                                  if_l.ser_first, if_l.ser_last, if_l.ser_out}), 32'(exp_vec(1'b0)));
    endtask

    task automatic cycle();
        bit acc;
        acc = rst_n && tb_valid && (exp_q.size() < 2);
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            pos = 0;
        end else begin
            if (exp_q.size() > 0) begin
                pos++;
                if (pos == W) begin
                    void'(exp_q.pop_front());
                    pos = 0;
                end
            end
            if (acc) exp_q.push_back(tb_data);
        end
        @(negedge clk);
        check_outputs("out");
        if (if_m.ser_valid) rx_m = {rx_m[W-2:0], if_m.ser_out};
        if (if_l.ser_valid) rx_l = {if_l.ser_out, rx_l[W-1:1]};
    endtask

    task automatic send_word(input logic [W-1:0] d, input bit keep, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        tb_valid = 1'b1;
        tb_data  = d;
        while (!acc && waited < 4*W) begin
            acc = (exp_q.size() < 2);
            cycle();
            waited++;
        end
        if (!acc) check_eq("send_timeout", 32'(0), 32'(1));
        if (!keep) tb_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 4*W) begin
            cycle();
            n++;
        end
        check_eq("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic single_frame(input logic [W-1:0] d);
        int waited;
        rx_m = '0;
        rx_l = '0;
        send_word(d, 1'b0, waited);
        drain();
        check_eq("rx_msb", 32'(rx_m), 32'(d));
        check_eq("rx_lsb", 32'(rx_l), 32'(d));
        cycle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int n;

        #1 rst_n = 1'b0;
        #1 check_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (20) cycle();

        single_frame(8'hA5);
        single_frame(8'h01);

        send_word(8'hA5, 1'b1, waited);
        send_word(8'h3C, 1'b0, waited);
        drain();
        cycle();

        // Offer a word exactly on the last-bit cycle with the hold buffer empty.
        send_word(8'h5A, 1'b0, waited);
        n = 0;
        while (!(exp_q.size() > 0 && pos == W-1) && n < 2*W) begin
            cycle();
            n++;
        end
        send_word(8'hC3, 1'b0, waited);
        check_eq("lastbit_wait", 32'(waited), 32'(1));
        drain();
        cycle();

        // Reset mid-frame with a word held.
        send_word(8'hFF, 1'b1, waited);
        send_word(8'h66, 1'b0, waited);
        cycle();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        pos = 0;
        check_outputs("rst_async");
        cycle();
        rst_n = 1'b1;
        single_frame(8'h81);

        repeat (400) begin
            tb_valid = ($urandom_range(0, 2) != 0);
            tb_data  = W'($urandom);
            cycle();
        end
        tb_valid = 1'b0;
        drain();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
